// File: rtl/codec_cfg_pkg.sv
// Shared types and the SSM2603 power-up table for the CODEC config arbiter.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    StStartup,
    StInitIssue,
    StInitDelay,
    StIdle,
    StWaitBusy,
    StWaitDone,
    StResp
  } state_e;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
    logic       wait_before;
  } init_entry_t;

  localparam int unsigned INIT_LEN = 10;

  // Power-up sequence; R9 (ACTIVE) must be preceded by the long settle delay.
  function automatic init_entry_t init_table(input logic [3:0] idx);
    init_entry_t e;
    case (idx)
      4'd0:    e = '{addr: 7'd15, data: 9'h000, wait_before: 1'b0};
      4'd1:    e = '{addr: 7'd6,  data: 9'h072, wait_before: 1'b0};
      4'd2:    e = '{addr: 7'd0,  data: 9'h017, wait_before: 1'b0};
      4'd3:    e = '{addr: 7'd1,  data: 9'h017, wait_before: 1'b0};
      4'd4:    e = '{addr: 7'd4,  data: 9'h012, wait_before: 1'b0};
      4'd5:    e = '{addr: 7'd5,  data: 9'h000, wait_before: 1'b0};
      4'd6:    e = '{addr: 7'd7,  data: 9'h00A, wait_before: 1'b0};
      4'd7:    e = '{addr: 7'd8,  data: 9'h000, wait_before: 1'b0};
      4'd8:    e = '{addr: 7'd9,  data: 9'h001, wait_before: 1'b1};
      4'd9:    e = '{addr: 7'd6,  data: 9'h062, wait_before: 1'b0};
      default: e = '{addr: 7'd0,  data: 9'h000, wait_before: 1'b0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/codec_cfg_arbiter_if.sv
// Requester and sequencer signals of the CODEC config arbiter.
interface codec_cfg_arbiter_if;
  logic       req0_valid, req0_rd, req0_ready, req0_done, req0_err;
  logic [6:0] req0_addr;
  logic [8:0] req0_wdata;
  logic [7:0] req0_rdata;
  logic       req1_valid, req1_rd, req1_ready, req1_done, req1_err;
  logic [6:0] req1_addr;
  logic [8:0] req1_wdata;
  logic [7:0] req1_rdata;
  logic       seq_rd_en, seq_wr_en;
  logic [7:0] seq_reg_addr;
  logic [8:0] seq_wdata;
  logic [7:0] seq_rdata;
  logic       seq_rdata_valid, seq_busy, seq_missed_ack;
  logic       init_done, init_error;

  // master: the arbiter itself; slave: requesters plus the I2C sequencer.
  modport master (
    input  req0_valid, req0_rd, req0_addr, req0_wdata,
    input  req1_valid, req1_rd, req1_addr, req1_wdata,
    output req0_ready, req0_done, req0_rdata, req0_err,
    output req1_ready, req1_done, req1_rdata, req1_err,
    output seq_rd_en, seq_wr_en, seq_reg_addr, seq_wdata,
    input  seq_rdata, seq_rdata_valid, seq_busy, seq_missed_ack,
    output init_done, init_error
  );
  modport slave (
    output req0_valid, req0_rd, req0_addr, req0_wdata,
    output req1_valid, req1_rd, req1_addr, req1_wdata,
    input  req0_ready, req0_done, req0_rdata, req0_err,
    input  req1_ready, req1_done, req1_rdata, req1_err,
    input  seq_rd_en, seq_wr_en, seq_reg_addr, seq_wdata,
    output seq_rdata, seq_rdata_valid, seq_busy, seq_missed_ack,
    input  init_done, init_error
  );
endinterface

// File: rtl/cfg_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, grants the requester not granted last.
module cfg_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);
  logic last_q, last_d;

  // Grant selection and last-grant update.
  always_comb begin
    case (valid_i)
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      default: gnt_o = 2'b00;
    endcase
    last_d = (en_i && (|gnt_o)) ? gnt_o[1] : last_q;
  end

  // Last-grant register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= 1'b0;
    else        last_q <= last_d;
  end
endmodule

// File: rtl/codec_cfg_arbiter.sv
// Owns the CODEC register port: replays the power-up table, then serves two requesters.
module codec_cfg_arbiter import codec_cfg_pkg::*; #(
  parameter int unsigned STARTUP_DELAY = 1000,
  parameter int unsigned ACTIVE_DELAY  = 100000,
  parameter int unsigned BUSY_TIMEOUT  = 64,
  parameter int unsigned MAX_RETRY     = 2
) (
  input logic                 clk,
  input logic                 reset,
  codec_cfg_arbiter_if.master bus
);
  state_e      state_q;
  logic [31:0] cnt_q;
  logic [3:0]  idx_q;
  logic [7:0]  retry_q;
  logic        waited_q, in_init_q, owner_q, rd_q, rvalid_q;
  logic [7:0]  rcap_q, rdata0_q, rdata1_q;
  logic        seq_rd_en_q, seq_wr_en_q;
  logic [6:0]  seq_addr_q;
  logic [8:0]  seq_wdata_q;
  logic [1:0]  ready_q, done_q, err_q;
  logic        init_done_q, init_error_q;

  init_entry_t entry;
  logic [1:0]  gnt;
  logic        grant_en, sel_rd;
  logic [6:0]  sel_addr;
  logic [8:0]  sel_wdata;
  logic        fin, fin_err, rd_ok;
  logic [7:0]  rdata_fin;

  cfg_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid_i ({bus.req1_valid, bus.req0_valid}),
    .en_i    (grant_en),
    .gnt_o   (gnt)
  );

  // Grant qualification, request mux and transaction-completion decode.
  always_comb begin
    entry     = init_table(idx_q);
    grant_en  = (state_q == StIdle) && !bus.seq_busy && (|gnt);
    sel_rd    = gnt[1] ? bus.req1_rd    : bus.req0_rd;
    sel_addr  = gnt[1] ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = gnt[1] ? bus.req1_wdata : bus.req0_wdata;
    rd_ok     = rvalid_q | bus.seq_rdata_valid;
    rdata_fin = bus.seq_rdata_valid ? bus.seq_rdata : rcap_q;
    fin       = 1'b0;
    fin_err   = 1'b0;
    if (state_q == StWaitBusy && !bus.seq_busy && cnt_q == 32'(BUSY_TIMEOUT - 1)) begin
      fin     = 1'b1;
      fin_err = 1'b1;
    end
    if (state_q == StWaitDone && !bus.seq_busy) begin
      fin     = 1'b1;
      fin_err = bus.seq_missed_ack | (rd_q & ~rd_ok);
    end
  end

  // Main FSM with registered strobes and responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StStartup;
      cnt_q        <= '0;
      idx_q        <= '0;
      retry_q      <= '0;
      waited_q     <= 1'b0;
      in_init_q    <= 1'b0;
      owner_q      <= 1'b0;
      rd_q         <= 1'b0;
      rvalid_q     <= 1'b0;
      rcap_q       <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      seq_rd_en_q  <= 1'b0;
      seq_wr_en_q  <= 1'b0;
      seq_addr_q   <= '0;
      seq_wdata_q  <= '0;
      ready_q      <= '0;
      done_q       <= '0;
      err_q        <= '0;
      init_done_q  <= 1'b0;
      init_error_q <= 1'b0;
    end else begin
      seq_rd_en_q <= 1'b0;
      seq_wr_en_q <= 1'b0;
      ready_q     <= '0;
      done_q      <= '0;
      unique case (state_q)
        StStartup: begin
          if (cnt_q == 32'(STARTUP_DELAY - 1)) begin
            cnt_q   <= '0;
            state_q <= StInitIssue;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StInitIssue: begin
          if (entry.wait_before && !waited_q) begin
            cnt_q   <= '0;
            state_q <= StInitDelay;
          end else begin
            seq_wr_en_q <= 1'b1;
            seq_addr_q  <= entry.addr;
            seq_wdata_q <= entry.data;
            rd_q        <= 1'b0;
            in_init_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StWaitBusy;
          end
        end
        StInitDelay: begin
          if (cnt_q == 32'(ACTIVE_DELAY - 1)) begin
            waited_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= StInitIssue;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StIdle: begin
          if (grant_en) begin
            owner_q     <= gnt[1];
            ready_q     <= gnt;
            rd_q        <= sel_rd;
            seq_rd_en_q <= sel_rd;
            seq_wr_en_q <= ~sel_rd;
            seq_addr_q  <= sel_addr;
            seq_wdata_q <= sel_wdata;
            in_init_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StWaitBusy;
          end
        end
        StWaitBusy: begin
          if (bus.seq_busy) state_q <= StWaitDone;
          else              cnt_q   <= cnt_q + 32'd1;
        end
        StWaitDone: begin
          if (bus.seq_rdata_valid) begin
            rcap_q   <= bus.seq_rdata;
            rvalid_q <= 1'b1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StStartup;
      endcase

      // Completion overrides the per-state next state.
      if (fin) begin
        cnt_q <= '0;
        if (in_init_q) begin
          if (!fin_err || retry_q == 8'(MAX_RETRY)) begin
            init_error_q <= init_error_q | fin_err;
            retry_q      <= '0;
            waited_q     <= 1'b0;
            if (idx_q == 4'(INIT_LEN - 1)) begin
              init_done_q <= 1'b1;
              state_q     <= StIdle;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= StInitIssue;
            end
          end else begin
            retry_q <= retry_q + 8'd1;
            state_q <= StInitIssue;
          end
        end else begin
          done_q <= owner_q ? 2'b10 : 2'b01;
          if (owner_q) begin
            err_q[1] <= fin_err;
            rdata1_q <= (rd_q && rd_ok) ? rdata_fin : 8'h00;
          end else begin
            err_q[0] <= fin_err;
            rdata0_q <= (rd_q && rd_ok) ? rdata_fin : 8'h00;
          end
          state_q <= StResp;
        end
      end
    end
  end

  assign bus.req0_ready   = ready_q[0];
  assign bus.req1_ready   = ready_q[1];
  assign bus.req0_done    = done_q[0];
  assign bus.req1_done    = done_q[1];
  assign bus.req0_err     = err_q[0];
  assign bus.req1_err     = err_q[1];
  assign bus.req0_rdata   = rdata0_q;
  assign bus.req1_rdata   = rdata1_q;
  assign bus.seq_rd_en    = seq_rd_en_q;
  assign bus.seq_wr_en    = seq_wr_en_q;
  assign bus.seq_reg_addr = {1'b0, seq_addr_q};
  assign bus.seq_wdata    = seq_wdata_q;
  assign bus.init_done    = init_done_q;
  assign bus.init_error   = init_error_q;
endmodule

// File: tb/tb_codec_cfg_arbiter.sv
// Scoreboard bench for codec_cfg_arbiter with a simple I2C sequencer model.
module tb_codec_cfg_arbiter;
  localparam int unsigned StartupDelay = 20;
  localparam int unsigned ActiveDelay  = 150;
  localparam int unsigned BusyTimeout  = 64;
  localparam int unsigned MaxRetry     = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  codec_cfg_arbiter_if bus ();

  codec_cfg_arbiter #(
    .STARTUP_DELAY (StartupDelay),
    .ACTIVE_DELAY  (ActiveDelay),
    .BUSY_TIMEOUT  (BusyTimeout),
    .MAX_RETRY     (MaxRetry)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rd;
    bit [6:0] addr;
    bit [8:0] data;
    int       min_gap;
  } strobe_t;

  typedef struct {
    int       who;
    bit       rd;
    bit [7:0] rdata;
    bit       err;
  } resp_t;

  strobe_t exp_strobe[$];
  resp_t   exp_resp[$];
  int      exp_grant[$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int last_strobe_cycle = 0;
  int grant_cycle = 0;
  bit       no_busy = 1'b0;
  bit [6:0] nack_addr = 7'h7F;
  bit [7:0] model_rdata = 8'h00;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {21'd0, bus.req0_ready, bus.req0_done, bus.req0_rdata, bus.req0_err,
            bus.req1_ready, bus.req1_done, bus.req1_rdata, bus.req1_err,
            bus.seq_rd_en, bus.seq_wr_en, bus.seq_reg_addr, bus.seq_wdata,
            bus.init_done, bus.init_error};
  endfunction

  task automatic push_strobe(input bit rd, input bit [6:0] addr, input bit [8:0] data,
                             input int min_gap);
    strobe_t s;
    s.rd = rd; s.addr = addr; s.data = data; s.min_gap = min_gap;
    exp_strobe.push_back(s);
  endtask

  task automatic push_resp(input int who, input bit rd, input bit [7:0] rdata, input bit err);
    resp_t r;
    r.who = who; r.rd = rd; r.rdata = rdata; r.err = err;
    exp_resp.push_back(r);
  endtask

  // Expected power-up writes; with nack4 the R4 write is tried 1 + MaxRetry times.
  task automatic push_init(input bit nack4);
    push_strobe(1'b0, 7'd15, 9'h000, int'(StartupDelay));
    push_strobe(1'b0, 7'd6,  9'h072, 0);
    push_strobe(1'b0, 7'd0,  9'h017, 0);
    push_strobe(1'b0, 7'd1,  9'h017, 0);
    push_strobe(1'b0, 7'd4,  9'h012, 0);
    if (nack4) begin
      push_strobe(1'b0, 7'd4, 9'h012, 0);
      push_strobe(1'b0, 7'd4, 9'h012, 0);
    end
    push_strobe(1'b0, 7'd5,  9'h000, 0);
    push_strobe(1'b0, 7'd7,  9'h00A, 0);
    push_strobe(1'b0, 7'd8,  9'h000, 0);
    push_strobe(1'b0, 7'd9,  9'h001, int'(ActiveDelay));
    push_strobe(1'b0, 7'd6,  9'h062, 0);
  endtask

  // Strobe monitor.
  strobe_t es;
  initial forever begin
    @(negedge clk);
    if (bus.seq_wr_en || bus.seq_rd_en) begin
      if (exp_strobe.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got addr 0x%0h wr=%0b, expected none",
                 bus.seq_reg_addr, bus.seq_wr_en);
      end else begin
        es = exp_strobe.pop_front();
        check("strobe_kind", 64'({bus.seq_rd_en, bus.seq_wr_en}), es.rd ? 64'd2 : 64'd1);
        check("strobe_addr", 64'(bus.seq_reg_addr), 64'({1'b0, es.addr}));
        if (!es.rd) check("strobe_wdata", 64'(bus.seq_wdata), 64'(es.data));
        if (es.min_gap > 0) begin
          checks++;
          if (cycle - last_strobe_cycle < es.min_gap) begin
            failures++;
            $display("FAIL strobe_gap: got %0d cycles, expected >= %0d",
                     cycle - last_strobe_cycle, es.min_gap);
          end
        end
      end
      last_strobe_cycle = cycle;
    end
  end

  // Grant monitor.
  int eg;
  initial forever begin
    @(negedge clk);
    if (bus.req0_ready || bus.req1_ready) begin
      grant_cycle = cycle;
      if (exp_grant.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant: got %0b%0b, expected none", bus.req1_ready,
                 bus.req0_ready);
      end else begin
        eg = exp_grant.pop_front();
        check("grant_onehot", 64'({bus.req1_ready, bus.req0_ready}), (eg == 1) ? 64'd2 : 64'd1);
      end
    end
  end

  // Response monitor.
  resp_t er;
  initial forever begin
    @(negedge clk);
    if (bus.req0_done || bus.req1_done) begin
      if (exp_resp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got %0b%0b, expected none", bus.req1_done,
                 bus.req0_done);
      end else begin
        er = exp_resp.pop_front();
        check("done_onehot", 64'({bus.req1_done, bus.req0_done}), (er.who == 1) ? 64'd2 : 64'd1);
        if (er.rd)
          check("done_rdata", 64'((er.who == 1) ? bus.req1_rdata : bus.req0_rdata),
                64'(er.rdata));
        check("done_err", 64'((er.who == 1) ? bus.req1_err : bus.req0_err), 64'(er.err));
      end
    end
  end

  // I2C sequencer model: busy rises one cycle after a strobe and lasts ~20 cycles.
  bit       m_rd;
  bit [6:0] m_addr;
  initial begin
    bus.seq_busy = 1'b0;
    bus.seq_missed_ack = 1'b0;
    bus.seq_rdata = 8'h00;
    bus.seq_rdata_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && (bus.seq_wr_en || bus.seq_rd_en) && !no_busy) begin
        m_rd = bus.seq_rd_en;
        m_addr = bus.seq_reg_addr[6:0];
        @(posedge clk);
        #1;
        bus.seq_busy = 1'b1;
        bus.seq_missed_ack = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        if (m_rd) begin
          bus.seq_rdata = model_rdata;
          bus.seq_rdata_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.seq_rdata_valid = 1'b0;
        bus.seq_missed_ack = (m_addr == nack_addr);
        bus.seq_busy = 1'b0;
      end
    end
  end

  task automatic drive_req(input int n, input bit rd, input bit [6:0] addr,
                           input bit [8:0] wdata, input bit drop);
    int t = 0;
    logic rdy;
    if (n == 0) begin
      bus.req0_rd = rd; bus.req0_addr = addr; bus.req0_wdata = wdata; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_rd = rd; bus.req1_addr = addr; bus.req1_wdata = wdata; bus.req1_valid = 1'b1;
    end
    do begin
      @(negedge clk);
      t++;
      rdy = (n == 0) ? bus.req0_ready : bus.req1_ready;
    end while (!rdy && t < 500);
    check("req_ready_seen", 64'(rdy), 64'd1);
    @(posedge clk);
    #1;
    if (drop) begin
      if (n == 0) bus.req0_valid = 1'b0;
      else        bus.req1_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_strobe.size() + exp_resp.size() + exp_grant.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_strobe.size() + exp_resp.size() + exp_grant.size()), 64'd0);
  endtask

  task automatic wait_init(input int budget);
    int n = 0;
    while (!bus.init_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("init_done", 64'(bus.init_done), 64'd1);
  endtask

  initial begin
    int n;
    bus.req0_valid = 1'b0; bus.req0_rd = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_rd = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    #2 reset = 1'b0;
    #1 check("reset_outputs", all_outputs(), 64'd0);

    // Power-up replay, all ACKed; a pending request must wait for init_done.
    push_init(1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    last_strobe_cycle = cycle;
    bus.req1_valid = 1'b1;
    bus.req1_addr = 7'h33;
    wait_init(3000);
    check("init_error_clean", 64'(bus.init_error), 64'd0);
    wait_drain("init_table_drained", 50);
    bus.req1_valid = 1'b0;
    bus.req1_addr = 7'h00;

    // Host read of R7 returning 0xA5.
    model_rdata = 8'hA5;
    push_strobe(1'b1, 7'h07, 9'h000, 0);
    exp_grant.push_back(0);
    push_resp(0, 1'b1, 8'hA5, 1'b0);
    drive_req(0, 1'b1, 7'h07, 9'h000, 1'b1);
    wait_drain("read_drained", 200);

    // Aux write to a sequencer that never goes busy: timeout error.
    no_busy = 1'b1;
    push_strobe(1'b0, 7'h05, 9'h1AB, 0);
    exp_grant.push_back(1);
    push_resp(1, 1'b0, 8'h00, 1'b1);
    drive_req(1, 1'b0, 7'h05, 9'h1AB, 1'b1);
    n = 0;
    while (!bus.req1_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("timeout_done_seen", 64'(bus.req1_done), 64'd1);
    checks++;
    if (cycle - grant_cycle < int'(BusyTimeout)) begin
      failures++;
      $display("FAIL timeout_latency: got %0d cycles, expected >= %0d", cycle - grant_cycle,
               BusyTimeout);
    end
    wait_drain("timeout_drained", 50);
    no_busy = 1'b0;

    // Both requesters continuously valid: grants alternate 0,1,0,1.
    push_strobe(1'b0, 7'h01, 9'h101, 0);
    push_strobe(1'b0, 7'h11, 9'h111, 0);
    push_strobe(1'b0, 7'h02, 9'h102, 0);
    push_strobe(1'b0, 7'h12, 9'h112, 0);
    exp_grant.push_back(0); exp_grant.push_back(1);
    exp_grant.push_back(0); exp_grant.push_back(1);
    push_resp(0, 1'b0, 8'h00, 1'b0); push_resp(1, 1'b0, 8'h00, 1'b0);
    push_resp(0, 1'b0, 8'h00, 1'b0); push_resp(1, 1'b0, 8'h00, 1'b0);
    fork
      begin
        drive_req(0, 1'b0, 7'h01, 9'h101, 1'b0);
        drive_req(0, 1'b0, 7'h02, 9'h102, 1'b1);
      end
      begin
        drive_req(1, 1'b0, 7'h11, 9'h111, 1'b0);
        drive_req(1, 1'b0, 7'h12, 9'h112, 1'b1);
      end
    join
    wait_drain("rr_drained", 300);

    // Reset in the middle of a transfer, then replay with R4 NACKed.
    push_strobe(1'b0, 7'h09, 9'h000, 0);
    exp_grant.push_back(0);
    drive_req(0, 1'b0, 7'h09, 9'h000, 1'b1);
    n = 0;
    while (!bus.seq_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_busy_seen", 64'(bus.seq_busy), 64'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 check("abort_outputs", all_outputs(), 64'd0);
    wait_drain("abort_drained", 5);
    nack_addr = 7'd4;
    push_init(1'b1);
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    last_strobe_cycle = cycle;
    wait_init(3000);
    check("init_error_nack", 64'(bus.init_error), 64'd1);
    wait_drain("replay_drained", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
